// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment display scan path.
package seg_pkg;

  localparam int unsigned DIGIT_W        = 4;
  localparam int unsigned NUM_DIGITS_DEF = 8;
  localparam int unsigned DIV_DEF        = 1000;

  typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Slot divider: asserts tick during the last cycle of every DIV-cycle digit slot.
module scan_tick_gen
  import seg_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  assign tick = (div_cnt == LAST);

  // Count 0..DIV-1 and restart on the tick cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hex_digit_scan.sv
// Multiplexed hex display scanner: double-buffered value, one-hot digit select
// and leading-zero blanking feeding the 7-segment decoder.
module hex_digit_scan
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int unsigned DIV        = DIV_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] data,
  input  logic                          blank_lz,
  output logic [DIGIT_W-1:0]            dig_val,
  output logic                          dig_en,
  output logic [NUM_DIGITS-1:0]         dig_sel,
  output logic                          frame_done
);

  localparam int unsigned   IW       = $clog2(NUM_DIGITS);
  localparam int unsigned   DW       = DIGIT_W * NUM_DIGITS;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic                  tick;
  logic                  boundary;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nxt;
  logic [DW-1:0]         stage;
  logic [DW-1:0]         disp;
  logic [DW-1:0]         disp_nxt;
  logic                  pending;
  logic                  pending_nxt;
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] sel_nxt;
  digit_t                val_nxt;
  logic                  en_nxt;

  scan_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Next digit index and double-buffer transfer; a load on the boundary edge bypasses staging.
  always_comb begin
    boundary    = tick && (idx == IDX_LAST);
    idx_nxt     = idx;
    disp_nxt    = disp;
    pending_nxt = pending;
    if (tick) begin
      idx_nxt = boundary ? '0 : idx + 1'b1;
    end
    if (boundary) begin
      if (load) begin
        disp_nxt = data;
      end else if (pending) begin
        disp_nxt = stage;
      end
      pending_nxt = 1'b0;
    end else if (load) begin
      pending_nxt = 1'b1;
    end
  end

  // Blank digit i when blanking is on, i > 0 and every digit from the top down to i is zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank      = '0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      int unsigned i;
      i          = NUM_DIGITS - 1 - j;
      zero_above = zero_above && (disp_nxt[i*DIGIT_W +: DIGIT_W] == '0);
      blank[i]   = blank_lz && (i != 0) && zero_above;
    end
  end

  // Select, value and enable for the digit that becomes current on this edge.
  always_comb begin
    sel_nxt = '0;
    val_nxt = '0;
    en_nxt  = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nxt == IW'(i)) begin
        sel_nxt[i] = 1'b1;
        val_nxt    = disp_nxt[i*DIGIT_W +: DIGIT_W];
        en_nxt     = !blank[i];
      end
    end
  end

  // Scan state and buffers; reset discards any pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      stage   <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else begin
      idx     <= idx_nxt;
      disp    <= disp_nxt;
      pending <= pending_nxt;
      if (load) begin
        stage <= data;
      end
    end
  end

  // Output registers. idx and disp only move on tick edges, so refreshing only
  // on ticks is equivalent and makes blank_lz take effect at the next tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_sel    <= NUM_DIGITS'(1);
      dig_val    <= '0;
      dig_en     <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (tick) begin
        dig_sel <= sel_nxt;
        dig_val <= val_nxt;
        dig_en  <= en_nxt;
      end
    end
  end

endmodule

// File: tb/tb_hex_digit_scan.sv
// Testbench for hex_digit_scan: 4 digits with DIV=3 against a frame-level model,
// plus a 4-digit DIV=1 instance checked for per-cycle rotation.
module tb_hex_digit_scan;

  localparam int N   = 4;
  localparam int DV  = 3;
  localparam int FRM = N * DV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  dig_val;
  logic        dig_en;
  logic [3:0]  dig_sel;
  logic        frame_done;

  logic [3:0]  dig_val2;
  logic        dig_en2;
  logic [3:0]  dig_sel2;
  logic        frame_done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hex_digit_scan #(.NUM_DIGITS(N), .DIV(DV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data       (data),
    .blank_lz   (blank_lz),
    .dig_val    (dig_val),
    .dig_en     (dig_en),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );

  hex_digit_scan #(.NUM_DIGITS(N), .DIV(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (1'b0),
    .data       (16'h0000),
    .blank_lz   (1'b0),
    .dig_val    (dig_val2),
    .dig_en     (dig_en2),
    .dig_sel    (dig_sel2),
    .frame_done (frame_done2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: mk counts edges since reset release; a frame is FRM
  // edges and slot boundaries fall on multiples of DV.
  int          mk;
  logic [15:0] shown, pend_val;
  bit          has_pend;
  int          m_idx;
  logic [3:0]  m_val;
  logic        m_en, m_fd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mk = 0; shown = '0; pend_val = '0; has_pend = 0;
      m_idx = 0; m_val = '0; m_en = 1'b1; m_fd = 1'b0;
    end else begin
      mk++;
      if (mk % FRM == 0) begin
        if (load) shown = data;
        else if (has_pend) shown = pend_val;
        has_pend = 0;
      end else if (load) begin
        has_pend = 1;
        pend_val = data;
      end
      m_fd = (mk % FRM == 0);
      if (mk % DV == 0) begin
        m_idx = (mk / DV) % N;
        m_val = 4'((shown >> (4 * m_idx)) & 16'h000F);
        m_en  = !(blank_lz && m_idx > 0 && (shown >> (4 * m_idx)) == 16'h0000);
      end
    end
  end

  // Compare both instances against expectations every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("sel", 32'(dig_sel), 32'(4'b0001 << m_idx));
      chk("val", 32'(dig_val), 32'(m_val));
      chk("en",  32'(dig_en),  32'(m_en));
      chk("fd",  32'(frame_done), 32'(m_fd));
      chk("div1_sel", 32'(dig_sel2), 32'(4'b0001 << (mk % N)));
      chk("div1_fd",  32'(frame_done2), 32'(mk > 0 && mk % N == 0));
      chk("div1_val", 32'(dig_val2), 32'h0);
      chk("div1_en",  32'(dig_en2), 32'h1);
    end
  end

  task automatic wait_edge(input int k);
    int guard;
    guard = 0;
    while (mk != k && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (mk != k) chk("wait_timeout", 32'(mk), 32'(k));
  endtask

  task automatic load_at(input int k, input logic [15:0] v);
    wait_edge(k - 1);
    load = 1'b1;
    data = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_sel", 32'(dig_sel), 32'h1);
    chk("rst_val", 32'(dig_val), 32'h0);
    chk("rst_en",  32'(dig_en),  32'h1);
    chk("rst_fd",  32'(frame_done), 32'h0);

    load_at(2, 16'h1234);
    chk("pre_val", 32'(dig_val), 32'h0);
    chk("pre_sel", 32'(dig_sel), 32'h1);
    wait_edge(12); chk("f1_fd", 32'(frame_done), 32'h1); chk("f1_d0", 32'(dig_val), 32'h4);
    wait_edge(13); chk("f1_fd_low", 32'(frame_done), 32'h0); chk("f1_d0_hold", 32'(dig_val), 32'h4);
    wait_edge(15); chk("f1_d1", 32'(dig_val), 32'h3); chk("f1_sel1", 32'(dig_sel), 32'h2);
    wait_edge(18); chk("f1_d2", 32'(dig_val), 32'h2);

    load_at(19, 16'hABCD);
    wait_edge(21); chk("tear_d3", 32'(dig_val), 32'h1); chk("tear_sel", 32'(dig_sel), 32'h8);
    wait_edge(24); chk("new_d0", 32'(dig_val), 32'hD);
    wait_edge(27); chk("new_d1", 32'(dig_val), 32'hC);

    load_at(36, 16'h00F0);
    chk("byp_val", 32'(dig_val), 32'h0);
    chk("byp_sel", 32'(dig_sel), 32'h1);
    chk("byp_fd",  32'(frame_done), 32'h1);
    wait_edge(39); chk("byp_d1", 32'(dig_val), 32'hF);

    load_at(40, 16'h1111);
    load_at(44, 16'h2222);
    wait_edge(48); chk("last_d0", 32'(dig_val), 32'h2);
    wait_edge(51); chk("last_d1", 32'(dig_val), 32'h2);

    load_at(50 + 3, 16'h0070);
    wait_edge(54); blank_lz = 1'b1;
    wait_edge(60); chk("lz70_e0", 32'(dig_en), 32'h1);
    load_at(62, 16'h0000);
    wait_edge(63); chk("lz70_e1", 32'(dig_en), 32'h1); chk("lz70_v1", 32'(dig_val), 32'h7);
    wait_edge(66); chk("lz70_e2", 32'(dig_en), 32'h0);
    wait_edge(69); chk("lz70_e3", 32'(dig_en), 32'h0);
    wait_edge(72); chk("lz0_e0", 32'(dig_en), 32'h1);
    wait_edge(75); chk("lz0_e1", 32'(dig_en), 32'h0);
    wait_edge(78); chk("lz0_e2", 32'(dig_en), 32'h0);
    wait_edge(81); chk("lz0_e3", 32'(dig_en), 32'h0);
    wait_edge(85); blank_lz = 1'b0;
    wait_edge(87); chk("nolz_e1", 32'(dig_en), 32'h1);
    wait_edge(90); chk("nolz_e2", 32'(dig_en), 32'h1);
    wait_edge(93); chk("nolz_e3", 32'(dig_en), 32'h1);

    load_at(98, 16'h5555);
    wait_edge(100);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_sel", 32'(dig_sel), 32'h1);
    chk("mrst_val", 32'(dig_val), 32'h0);
    chk("mrst_en",  32'(dig_en),  32'h1);
    chk("mrst_fd",  32'(frame_done), 32'h0);
    chk("mrst_sel1", 32'(dig_sel2), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_edge(12); chk("post_d0", 32'(dig_val), 32'h0); chk("post_fd", 32'(frame_done), 32'h1);
    wait_edge(15); chk("post_d1", 32'(dig_val), 32'h0); chk("post_e1", 32'(dig_en), 32'h1);
    wait_edge(24); chk("post_f2", 32'(dig_val), 32'h0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
